// File: rtl/ws2812b_chain_out.sv
// WS2812B serial line driver: streams LED words (MSB first) as T0H/T1H pulses, then a latch gap.
// Optional WS2812B_CHAIN_OUT_FRAME_COUNT_EN builds the 16-bit completed-frame counter.
module ws2812b_chain_out #(
    parameter int BITS_PER_LED   = 24,
    parameter int LEDS_PER_FRAME = 64,
    parameter int CYCLES_T0H     = 3,
    parameter int CYCLES_T1H     = 5,
    parameter int CYCLES_BIT     = 8,
    parameter int CYCLES_RET     = 450
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pixel_valid,
    input  logic [BITS_PER_LED-1:0] pixel_data,
    output logic                    pixel_ready,
    output logic                    ws2812b_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun,
    output logic [15:0]             frame_count
);

    localparam int CNT_MAX = (CYCLES_BIT > CYCLES_RET) ? CYCLES_BIT : CYCLES_RET;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
    localparam int PW      = (LEDS_PER_FRAME > 1) ? $clog2(LEDS_PER_FRAME) : 1;
    localparam int MSB     = BITS_PER_LED - 1;

    // Counter reload values are "duration - 1": a phase ends when the counter reads zero.
    localparam logic [CW-1:0] T0H_LOAD  = CW'(CYCLES_T0H - 1);
    localparam logic [CW-1:0] T1H_LOAD  = CW'(CYCLES_T1H - 1);
    localparam logic [CW-1:0] LOW0_LOAD = CW'(CYCLES_BIT - CYCLES_T0H - 1);
    localparam logic [CW-1:0] LOW1_LOAD = CW'(CYCLES_BIT - CYCLES_T1H - 1);
    localparam logic [CW-1:0] RET_LOAD  = CW'(CYCLES_RET - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_LED - 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(LEDS_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           count_reg, count_next;
    logic [BITS_PER_LED-1:0] shift_reg, shift_next;
    logic [BW-1:0]           bit_reg, bit_next;
    logic [PW-1:0]           pixel_reg, pixel_next;
    logic                    data_reg, underrun_reg, underrun_next;
    logic                    frame_done_reg, frame_done_next;
    logic                    ready_raw;
    logic                    last_cycle, last_bit, more_pixels;

    assign last_cycle  = (count_reg == '0);
    assign last_bit    = (bit_reg == LAST_BIT);
    assign more_pixels = (pixel_reg < LAST_PIX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            shift_reg      <= '0;
            bit_reg        <= '0;
            pixel_reg      <= '0;
            data_reg       <= 1'b0;
            underrun_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            shift_reg      <= shift_next;
            bit_reg        <= bit_next;
            pixel_reg      <= pixel_next;
            data_reg       <= (state_next == HIGH);
            underrun_reg   <= underrun_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        shift_next      = shift_reg;
        bit_next        = bit_reg;
        pixel_next      = pixel_reg;
        underrun_next   = 1'b0;
        frame_done_next = 1'b0;
        ready_raw       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_raw = 1'b1;
                if (pixel_valid) begin
                    shift_next = pixel_data;
                    bit_next   = '0;
                    pixel_next = '0;
                    count_next = pixel_data[MSB] ? T1H_LOAD : T0H_LOAD;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (last_cycle) begin
                    count_next = shift_reg[MSB] ? LOW1_LOAD : LOW0_LOAD;
                    state_next = LOW;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            LOW: begin
                if (!last_cycle) begin
                    count_next = count_reg - CW'(1);
                end else if (!last_bit) begin
                    shift_next = shift_reg << 1;
                    bit_next   = bit_reg + BW'(1);
                    count_next = shift_reg[MSB-1] ? T1H_LOAD : T0H_LOAD;
                    state_next = HIGH;
                end else begin
                    // Word boundary: the only in-frame cycle where the next word may be taken.
                    ready_raw = more_pixels;
                    if (more_pixels && pixel_valid) begin
                        shift_next = pixel_data;
                        bit_next   = '0;
                        pixel_next = pixel_reg + PW'(1);
                        count_next = pixel_data[MSB] ? T1H_LOAD : T0H_LOAD;
                        state_next = HIGH;
                    end else begin
                        underrun_next = more_pixels;
                        count_next    = RET_LOAD;
                        state_next    = LATCH;
                    end
                end
            end
            LATCH: begin
                if (last_cycle) begin
                    frame_done_next = 1'b1;
                    state_next      = IDLE;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is gated by reset directly so it drops without waiting for a clock edge.
    assign pixel_ready  = ready_raw & ~reset;
    assign ws2812b_data = data_reg;
    assign busy         = (state_reg != IDLE);
    assign underrun     = underrun_reg;
    assign frame_done   = frame_done_reg;

`ifdef WS2812B_CHAIN_OUT_FRAME_COUNT_EN
    logic [15:0] frame_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_reg <= '0;
        end else if (frame_done_next) begin
            frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    assign frame_count = frame_count_reg;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_ws2812b_chain_out.sv
// Randomized bench for ws2812b_chain_out: each frame's expected line waveform and handshake
// timing are rebuilt from the word list and the bit timing rules, then compared cycle by cycle.
module tb_ws2812b_chain_out;

    localparam int W        = 24;
    localparam int N        = 3;
    localparam int T0H      = 3;
    localparam int T1H      = 5;
    localparam int TBIT     = 8;
    localparam int TRET     = 450;
    localparam int WORD_CYC = W * TBIT;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pixel_valid = 1'b0;
    logic [W-1:0] pixel_data = '0;
    logic         pixel_ready, ws2812b_data, busy, frame_done, underrun;
    logic [15:0]  frame_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fc_model = 16'd0;

    always #5 clk = ~clk;

    ws2812b_chain_out #(
        .BITS_PER_LED  (W),
        .LEDS_PER_FRAME(N),
        .CYCLES_T0H    (T0H),
        .CYCLES_T1H    (T1H),
        .CYCLES_BIT    (TBIT),
        .CYCLES_RET    (TRET)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .pixel_ready (pixel_ready),
        .ws2812b_data(ws2812b_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun),
        .frame_count (frame_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fc_exp();
`ifdef WS2812B_CHAIN_OUT_FRAME_COUNT_EN
        return fc_model;
`else
        return 16'd0;
`endif
    endfunction

    // Offers k words (k < N truncates the frame) after an idle gap; called just after a negedge.
    task automatic run_frame(input int k, input int gap);
        logic [W-1:0] words [N];
        bit           exp_line [$];
        int           len, xfers, nxt, idle_err, waited, wi;
        int           e_data, e_busy, e_rdy, e_und, e_fd;
        bit           xfer_pend, rdy_exp;
        for (int i = 0; i < k; i++) words[i] = W'($urandom);
        exp_line = {};
        for (int i = 0; i < k; i++) begin
            for (int b = W - 1; b >= 0; b--) begin
                int h;
                h = words[i][b] ? T1H : T0H;
                for (int t = 0; t < TBIT; t++) exp_line.push_back(t < h);
            end
        end
        for (int t = 0; t < TRET; t++) exp_line.push_back(1'b0);
        len = exp_line.size();

        idle_err = 0;
        for (int g = 0; g < gap; g++) begin
            pixel_valid = 1'b0;
            pixel_data  = W'($urandom);
            @(negedge clk);
            if (ws2812b_data !== 1'b0 || busy !== 1'b0 || pixel_ready !== 1'b1 ||
                frame_done !== 1'b0 || underrun !== 1'b0) idle_err++;
        end
        check_val("idle_bad_cycles", idle_err, 0);

        pixel_valid = 1'b1;
        pixel_data  = words[0];
        #1;
        waited = 0;
        while (!pixel_ready && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check_val("idle_ready", pixel_ready, 1);
        if (pixel_ready !== 1'b1) begin
            pixel_valid = 1'b0;
            return;
        end

        xfer_pend = 1'b1;
        xfers = 1;
        nxt = 0;
        e_data = 0; e_busy = 0; e_rdy = 0; e_und = 0; e_fd = 0;
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            if (xfer_pend) begin
                nxt++;
                if (nxt < k) begin
                    pixel_valid = 1'b1;
                    pixel_data  = words[nxt];
                end else begin
                    pixel_valid = 1'b0;
                    pixel_data  = W'($urandom);
                end
            end
            wi = (c + 1) / WORD_CYC - 1;
            if (c < len)
                rdy_exp = ((c + 1) % WORD_CYC == 0) && (wi < k) && (wi < N - 1);
            else
                rdy_exp = 1'b1;
            if (ws2812b_data !== ((c < len) ? exp_line[c] : 1'b0)) e_data++;
            if (busy !== (c < len)) e_busy++;
            if (pixel_ready !== rdy_exp) e_rdy++;
            if (underrun !== ((k < N) && (c == k * WORD_CYC))) e_und++;
            if (frame_done !== (c == len)) e_fd++;
            if (c == len) begin
                fc_model = fc_model + 16'd1;
                check_val("frame_count", frame_count, fc_exp());
            end
            xfer_pend = pixel_ready && pixel_valid;
            if (xfer_pend) xfers++;
        end
        check_val("line_bad_cycles", e_data, 0);
        check_val("busy_bad_cycles", e_busy, 0);
        check_val("ready_bad_cycles", e_rdy, 0);
        check_val("underrun_bad_cycles", e_und, 0);
        check_val("frame_done_bad_cycles", e_fd, 0);
        check_val("transfers", xfers, k);
        $display("frame k=%0d gap=%0d len=%0d transfers=%0d frame_count=%0d", k, gap, len, xfers, frame_count);
    endtask

    // Starts a frame, asserts reset during the 10th bit, holds it, and leaves reset released.
    task automatic reset_mid_frame();
        int rst_err;
        pixel_valid = 1'b1;
        pixel_data  = W'($urandom);
        #1;
        check_val("rst_start_ready", pixel_ready, 1);
        @(negedge clk);
        pixel_valid = 1'b0;
        pixel_data  = W'($urandom);
        repeat (9 * TBIT + 2) @(negedge clk);
        check_val("rst_pre_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_val("rst_line", ws2812b_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", pixel_ready, 0);
        check_val("rst_frame_count", frame_count, 0);
        fc_model = 16'd0;
        rst_err = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || ws2812b_data !== 1'b0 || busy !== 1'b0 ||
                underrun !== 1'b0 || pixel_ready !== 1'b0) rst_err++;
        end
        check_val("rst_hold_bad_cycles", rst_err, 0);
        $display("reset asserted mid-frame, held 3 cycles");
        reset = 1'b0;
    endtask

    initial begin
        #1;
        check_val("por_line", ws2812b_data, 0);
        check_val("por_busy", busy, 0);
        check_val("por_ready", pixel_ready, 0);
        check_val("por_frame_done", frame_done, 0);
        check_val("por_underrun", underrun, 0);
        check_val("por_frame_count", frame_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_frame(N, 0);
        run_frame(1, 5);
        run_frame(2, 3);
        for (int f = 0; f < 3; f++) run_frame($urandom_range(1, N), $urandom_range(0, 10));
        reset_mid_frame();
        run_frame(N, 0);
        run_frame($urandom_range(1, N), $urandom_range(0, 10));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
